// File: rtl/config_loader.sv
// config_loader: buffers {addr, data, last} entries in a small FIFO and
// broadcasts each legal entry on config_addr/config_data for HOLD_CYCLES
// cycles. Entries whose module id is not a tile module are dropped and flagged.
//
// Handshake: an upstream entry is transferred on a rising edge where
// in_valid && in_ready. in_ready depends only on registered state (RUN and
// FIFO not full), never on in_valid or on a same-cycle pop.
module config_loader #(
   parameter int          HOLD_CYCLES = 1,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [31:0] IDLE_ADDR   = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_data,
   input  logic        in_last,
   output logic [31:0] config_addr,
   output logic [31:0] config_data,
   output logic        busy,
   output logic        done,
   output logic [15:0] word_count,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
   localparam logic [3:0]  HOLD_LAST = 4'(HOLD_CYCLES - 1);

   state_t        state;
   logic [64:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic          holding;
   logic [3:0]    hold_cnt;
   logic          hold_last;

   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          emit_free;
   logic          hold_done;
   logic [64:0]   head;
   logic          head_last;
   logic [31:0]   head_addr;
   logic [31:0]   head_data;
   logic          head_legal;

   // FIFO status, head decode and the emitter's pop decision
   always_comb begin
      fifo_full  = (count == FULL_CNT);
      fifo_empty = (count == '0);
      head       = mem[rd_ptr];
      head_last  = head[64];
      head_addr  = head[63:32];
      head_data  = head[31:0];
      head_legal = (head_addr[31:16] >= 16'd4) && (head_addr[31:16] <= 16'd7);
      hold_done  = (hold_cnt == HOLD_LAST);
      // The emitter can take a new entry when nothing is held, or when the
      // current hold ends and it is not the session's final word.
      emit_free  = !holding || (hold_done && !hold_last);
      push       = in_valid && in_ready;
      pop        = (state == S_RUN) && emit_free && !fifo_empty;
   end

   assign in_ready = (state == S_RUN) && !fifo_full;
   assign busy     = (state == S_RUN);
   assign done     = (state == S_DONE);

   // FIFO storage; flushing is done through the pointers, so no reset here
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_last, in_addr, in_data};
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Session FSM and emitter: holds words, drops illegal entries, ends on last
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         holding     <= 1'b0;
         hold_cnt    <= 4'd0;
         hold_last   <= 1'b0;
         config_addr <= IDLE_ADDR;
         config_data <= 32'h0;
         word_count  <= 16'h0;
         err         <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               config_addr <= IDLE_ADDR;
               config_data <= 32'h0;
               holding     <= 1'b0;
               if (start) begin
                  state      <= S_RUN;
                  word_count <= 16'h0;
                  err        <= 1'b0;
               end
            end
            S_RUN: begin
               if (holding && !hold_done) begin
                  hold_cnt <= hold_cnt + 4'd1;
               end else if (holding && hold_last) begin
                  // Final word's hold has ended: session complete
                  holding     <= 1'b0;
                  config_addr <= IDLE_ADDR;
                  config_data <= 32'h0;
                  state       <= S_DONE;
               end else if (!fifo_empty) begin
                  if (head_legal) begin
                     holding     <= 1'b1;
                     hold_cnt    <= 4'd0;
                     hold_last   <= head_last;
                     config_addr <= head_addr;
                     config_data <= head_data;
                     if (word_count != 16'hFFFF) begin
                        word_count <= word_count + 16'd1;
                     end
                  end else begin
                     // Dropped entry: never presented, but still may end the session
                     holding     <= 1'b0;
                     config_addr <= IDLE_ADDR;
                     config_data <= 32'h0;
                     err         <= 1'b1;
                     if (head_last) state <= S_DONE;
                  end
               end else begin
                  holding     <= 1'b0;
                  config_addr <= IDLE_ADDR;
                  config_data <= 32'h0;
               end
            end
            default: begin
               state       <= S_IDLE;
               holding     <= 1'b0;
               config_addr <= IDLE_ADDR;
               config_data <= 32'h0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: three instances (hold 1, 3 and 15 cycles) share
// clock and reset; each scenario task drives one instance and checks inline.
module tb_config_loader;

   localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        start       [3];
   logic        in_valid    [3];
   logic        in_ready    [3];
   logic [31:0] in_addr     [3];
   logic [31:0] in_data     [3];
   logic        in_last     [3];
   logic [31:0] config_addr [3];
   logic [31:0] config_data [3];
   logic        busy        [3];
   logic        done        [3];
   logic [15:0] word_count  [3];
   logic        err         [3];

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_q [$];
   logic [31:0] got_addr [$];
   logic [31:0] got_data [$];
   int          got_len [$];
   int          nonidle;
   int          first_idx;
   int          last_idx;

   // clock / reset block
   always #5 clk = ~clk;

   config_loader #(.HOLD_CYCLES(1)) dut0 (
      .clk(clk), .reset(reset), .start(start[0]), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .in_addr(in_addr[0]), .in_data(in_data[0]),
      .in_last(in_last[0]), .config_addr(config_addr[0]),
      .config_data(config_data[0]), .busy(busy[0]), .done(done[0]),
      .word_count(word_count[0]), .err(err[0]));

   config_loader #(.HOLD_CYCLES(3)) dut1 (
      .clk(clk), .reset(reset), .start(start[1]), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .in_addr(in_addr[1]), .in_data(in_data[1]),
      .in_last(in_last[1]), .config_addr(config_addr[1]),
      .config_data(config_data[1]), .busy(busy[1]), .done(done[1]),
      .word_count(word_count[1]), .err(err[1]));

   config_loader #(.HOLD_CYCLES(15)) dut2 (
      .clk(clk), .reset(reset), .start(start[2]), .in_valid(in_valid[2]),
      .in_ready(in_ready[2]), .in_addr(in_addr[2]), .in_data(in_data[2]),
      .in_last(in_last[2]), .config_addr(config_addr[2]),
      .config_data(config_data[2]), .busy(busy[2]), .done(done[2]),
      .word_count(word_count[2]), .err(err[2]));

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int k);
      start[k] = 1'b1;
      tick();
      start[k] = 1'b0;
   endtask

   task automatic push(input int k, input logic [31:0] a, input logic [31:0] d,
                       input logic l);
      int waited;
      waited     = 0;
      in_valid[k] = 1'b1;
      in_addr[k]  = a;
      in_data[k]  = d;
      in_last[k]  = l;
      while (in_ready[k] !== 1'b1 && waited < 100) begin
         tick();
         waited++;
      end
      checks++;
      if (waited >= 100) begin
         errors++;
         $display("FAIL push_timeout: dut%0d in_ready=%b required 1 within 100 cycles", k, in_ready[k]);
      end
      tick();
      in_valid[k] = 1'b0;
      in_last[k]  = 1'b0;
   endtask

   // Records runs of identical non-idle addresses over n cycles
   task automatic watch(input int k, input int n);
      logic [31:0] prev;
      prev = IDLE;
      got_addr.delete();
      got_data.delete();
      got_len.delete();
      nonidle   = 0;
      first_idx = -1;
      last_idx  = -1;
      for (int i = 0; i < n; i++) begin
         tick();
         if (config_addr[k] !== IDLE) begin
            nonidle++;
            if (first_idx < 0) first_idx = i;
            last_idx = i;
            if (config_addr[k] !== prev) begin
               got_addr.push_back(config_addr[k]);
               got_data.push_back(config_data[k]);
               got_len.push_back(1);
            end else begin
               got_len[got_len.size()-1] = got_len[got_len.size()-1] + 1;
            end
         end
         prev = config_addr[k];
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      checks++; if (config_addr[0] !== IDLE) begin errors++; $display("FAIL reset_addr: got %h required %h", config_addr[0], IDLE); end
      checks++; if (config_data[0] !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", config_data[0]); end
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy[0]); end
      checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done[0]); end
      checks++; if (word_count[0] !== 16'h0) begin errors++; $display("FAIL reset_wc: got %0d required 0", word_count[0]); end
      checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err[0]); end
      checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready[0]); end
   endtask

   task automatic test_single_write();
      pulse_start(0);
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL single_busy: got %b required 1", busy[0]); end
      in_valid[0] = 1'b1;
      in_addr[0]  = 32'h0004_0003;
      in_data[0]  = 32'h2;
      in_last[0]  = 1'b1;
      checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL single_ready: got %b required 1", in_ready[0]); end
      tick();
      in_valid[0] = 1'b0;
      in_last[0]  = 1'b0;
      checks++; if (config_addr[0] !== IDLE) begin errors++; $display("FAIL single_lat1: got %h required %h", config_addr[0], IDLE); end
      tick();
      checks++; if (config_addr[0] !== 32'h0004_0003) begin errors++; $display("FAIL single_addr: got %h required 00040003", config_addr[0]); end
      checks++; if (config_data[0] !== 32'h2) begin errors++; $display("FAIL single_data: got %h required 2", config_data[0]); end
      tick();
      checks++; if (config_addr[0] !== IDLE) begin errors++; $display("FAIL single_after_addr: got %h required %h", config_addr[0], IDLE); end
      checks++; if (config_data[0] !== 32'h0) begin errors++; $display("FAIL single_after_data: got %h required 0", config_data[0]); end
      checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL single_done: got %b required 1", done[0]); end
      checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b required 0", busy[0]); end
      checks++; if (word_count[0] !== 16'd1) begin errors++; $display("FAIL single_wc: got %0d required 1", word_count[0]); end
   endtask

   task automatic test_back_to_back();
      exp_q.delete();
      for (int j = 0; j < 4; j++) exp_q.push_back({16'(4 + j), 16'(j + 1)});
      pulse_start(1);
      fork
         begin
            for (int j = 0; j < 4; j++) push(1, exp_q[j], 32'h10 + 32'(j), j == 3);
         end
         watch(1, 20);
      join
      checks++; if (got_addr.size() != 4) begin errors++; $display("FAIL b2b_words: got %0d required 4", got_addr.size()); end
      for (int j = 0; j < 4 && j < got_addr.size(); j++) begin
         checks++; if (got_addr[j] !== exp_q[j]) begin errors++; $display("FAIL b2b_addr%0d: got %h required %h", j, got_addr[j], exp_q[j]); end
         checks++; if (got_data[j] !== 32'h10 + 32'(j)) begin errors++; $display("FAIL b2b_data%0d: got %h required %h", j, got_data[j], 32'h10 + 32'(j)); end
         checks++; if (got_len[j] != 3) begin errors++; $display("FAIL b2b_hold%0d: got %0d required 3", j, got_len[j]); end
      end
      checks++; if (nonidle != 12) begin errors++; $display("FAIL b2b_cycles: got %0d required 12", nonidle); end
      checks++; if (last_idx - first_idx != 11) begin errors++; $display("FAIL b2b_gap: span %0d required 11", last_idx - first_idx); end
      checks++; if (first_idx != 1) begin errors++; $display("FAIL b2b_latency: first at %0d required 1", first_idx); end
      checks++; if (word_count[1] !== 16'd4) begin errors++; $display("FAIL b2b_wc: got %0d required 4", word_count[1]); end
      checks++; if (done[1] !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b required 1", done[1]); end
   endtask

   task automatic test_illegal_module();
      exp_q.delete();
      exp_q.push_back(32'h0004_00AA);
      exp_q.push_back(32'h0007_00BB);
      pulse_start(1);
      fork
         begin
            push(1, 32'h0004_00AA, 32'h1, 1'b0);
            push(1, 32'h0009_0000, 32'h9, 1'b0);
            push(1, 32'h0007_00BB, 32'h2, 1'b1);
         end
         watch(1, 14);
      join
      checks++; if (got_addr.size() != 2) begin errors++; $display("FAIL ill_words: got %0d required 2", got_addr.size()); end
      for (int j = 0; j < 2 && j < got_addr.size(); j++) begin
         checks++; if (got_addr[j] !== exp_q[j]) begin errors++; $display("FAIL ill_addr%0d: got %h required %h", j, got_addr[j], exp_q[j]); end
      end
      checks++; if (nonidle != 6) begin errors++; $display("FAIL ill_cycles: got %0d required 6", nonidle); end
      checks++; if (err[1] !== 1'b1) begin errors++; $display("FAIL ill_err: got %b required 1", err[1]); end
      checks++; if (word_count[1] !== 16'd2) begin errors++; $display("FAIL ill_wc: got %0d required 2", word_count[1]); end
      checks++; if (done[1] !== 1'b1) begin errors++; $display("FAIL ill_done: got %b required 1", done[1]); end
   endtask

   task automatic test_backpressure();
      int n;
      logic r;
      exp_q.delete();
      exp_q.push_back(32'h0004_0000);
      for (int j = 0; j < 4; j++) exp_q.push_back({16'h0005, 16'(j + 1)});
      pulse_start(2);
      n = 0;
      fork
         begin
            push(2, 32'h0004_0000, 32'hA0, 1'b0);
            tick();
            for (int c = 0; c < 8; c++) begin
               in_valid[2] = 1'b1;
               in_addr[2]  = (n < 4) ? exp_q[n + 1] : 32'h0004_0EEE;
               in_data[2]  = 32'hB0 + 32'(n);
               in_last[2]  = (n == 3);
               r = in_ready[2];
               tick();
               if (r) n++;
            end
            in_valid[2] = 1'b0;
            in_last[2]  = 1'b0;
            checks++; if (in_ready[2] !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b required 0", in_ready[2]); end
         end
         watch(2, 85);
      join
      checks++; if (n != 4) begin errors++; $display("FAIL bp_accepts: got %0d required 4", n); end
      checks++; if (got_addr.size() != 5) begin errors++; $display("FAIL bp_words: got %0d required 5", got_addr.size()); end
      for (int j = 0; j < 5 && j < got_addr.size(); j++) begin
         checks++; if (got_addr[j] !== exp_q[j]) begin errors++; $display("FAIL bp_addr%0d: got %h required %h", j, got_addr[j], exp_q[j]); end
         checks++; if (got_len[j] != 15) begin errors++; $display("FAIL bp_hold%0d: got %0d required 15", j, got_len[j]); end
      end
      checks++; if (word_count[2] !== 16'd5) begin errors++; $display("FAIL bp_wc: got %0d required 5", word_count[2]); end
      checks++; if (done[2] !== 1'b1) begin errors++; $display("FAIL bp_done: got %b required 1", done[2]); end
   endtask

   task automatic test_reset_mid_hold();
      pulse_start(1);
      push(1, 32'h0006_0001, 32'h61, 1'b0);
      push(1, 32'h0006_0002, 32'h62, 1'b0);
      checks++; if (config_addr[1] !== 32'h0006_0001) begin errors++; $display("FAIL rmh_holding: got %h required 00060001", config_addr[1]); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (config_addr[1] !== IDLE) begin errors++; $display("FAIL rmh_addr: got %h required %h", config_addr[1], IDLE); end
      checks++; if (config_data[1] !== 32'h0) begin errors++; $display("FAIL rmh_data: got %h required 0", config_data[1]); end
      checks++; if (busy[1] !== 1'b0 || done[1] !== 1'b0) begin errors++; $display("FAIL rmh_state: busy=%b done=%b required 0 0", busy[1], done[1]); end
      checks++; if (word_count[1] !== 16'd0) begin errors++; $display("FAIL rmh_wc: got %0d required 0", word_count[1]); end
      checks++; if (in_ready[1] !== 1'b0) begin errors++; $display("FAIL rmh_ready: got %b required 0", in_ready[1]); end
      pulse_start(1);
      checks++; if (busy[1] !== 1'b1 || in_ready[1] !== 1'b1) begin errors++; $display("FAIL rmh_restart: busy=%b in_ready=%b required 1 1", busy[1], in_ready[1]); end
      watch(1, 6);
      checks++; if (nonidle != 0) begin errors++; $display("FAIL rmh_flushed: got %0d words cycles required 0", nonidle); end
   endtask

   task automatic test_restart();
      pulse_start(0);
      push(0, 32'h0009_0001, 32'h5, 1'b1);
      tick();
      checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL rs_err_set: got %b required 1", err[0]); end
      checks++; if (done[0] !== 1'b1) begin errors++; $display("FAIL rs_drop_last_done: got %b required 1", done[0]); end
      checks++; if (word_count[0] !== 16'd0) begin errors++; $display("FAIL rs_drop_wc: got %0d required 0", word_count[0]); end
      checks++; if (config_addr[0] !== IDLE) begin errors++; $display("FAIL rs_drop_addr: got %h required %h", config_addr[0], IDLE); end
      pulse_start(0);
      checks++; if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin errors++; $display("FAIL rs_state: busy=%b done=%b required 1 0", busy[0], done[0]); end
      checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL rs_err_clear: got %b required 0", err[0]); end
      checks++; if (word_count[0] !== 16'd0) begin errors++; $display("FAIL rs_wc_clear: got %0d required 0", word_count[0]); end
      pulse_start(0);
      checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL rs_start_in_run: busy=%b required 1", busy[0]); end
      reset    = 1'b1;
      start[0] = 1'b1;
      tick();
      reset    = 1'b0;
      start[0] = 1'b0;
      checks++; if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin errors++; $display("FAIL rs_reset_wins: busy=%b done=%b required 0 0", busy[0], done[0]); end
   endtask

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         start[k]    = 1'b0;
         in_valid[k] = 1'b0;
         in_addr[k]  = 32'h0;
         in_data[k]  = 32'h0;
         in_last[k]  = 1'b0;
      end
      test_reset();
      test_single_write();
      test_back_to_back();
      test_illegal_module();
      test_backpressure();
      test_reset_mid_hold();
      test_restart();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
